mul_accumulator: RTL and testbench

MUL_ACCUMULATOR -- requirements
Module: mul_accumulator

---
 rtl/mul_acc_pkg.sv | 21 ++
 rtl/sat_clamp.sv | 42 ++++
 rtl/mul_accumulator.sv | 114 +++++++++++
 tb/tb_mul_accumulator.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_acc_pkg.sv
// ============================================================================
// mul_acc_pkg : shared constants and state encoding for mul_accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

package mul_acc_pkg;

  localparam int ACC_W         = 64;
  localparam int GUARD_DEFAULT = 8;
  localparam int LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sat_clamp.sv
// ============================================================================
// sat_clamp : clamps a wide signed sum to ACC_W bits and flags saturation
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_clamp
  import mul_acc_pkg::*;
#(
  parameter int GUARD = GUARD_DEFAULT
) (
  input  logic [ACC_W+GUARD-1:0] i_sum,
  output logic [ACC_W-1:0]       o_acc,
  output logic                   o_sat
);

  localparam int IN_W = ACC_W + GUARD;

  // The value fits only when every bit from the ACC_W sign bit upward agrees.
  logic [GUARD:0] w_hi;
  logic           w_pos_ovf;
  logic           w_neg_ovf;

  assign w_hi      = i_sum[IN_W-1:ACC_W-1];
  assign w_pos_ovf = ~i_sum[IN_W-1] & (|w_hi);
  assign w_neg_ovf =  i_sum[IN_W-1] & ~(&w_hi);

  always_comb begin
    o_acc = i_sum[ACC_W-1:0];
    o_sat = 1'b0;
    if (w_pos_ovf) begin
      o_acc = {1'b0, {(ACC_W-1){1'b1}}};
      o_sat = 1'b1;
    end else if (w_neg_ovf) begin
      o_acc = {1'b1, {(ACC_W-1){1'b0}}};
      o_sat = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mul_accumulator.sv
// ============================================================================
// mul_accumulator : sums a block of signed products and returns a saturated result
// Rev 1.0
// ============================================================================
`default_nettype none

module mul_accumulator
  import mul_acc_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEFAULT,
  parameter int GUARD = GUARD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             prod_valid,
  input  logic [63:0]      prod,
  output logic             prod_ready,
  output logic             acc_valid,
  output logic [63:0]      acc,
  output logic             acc_sat,
  input  logic             acc_ready,
  output logic             busy
);

  localparam int SUM_W = ACC_W + GUARD;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [SUM_W-1:0]   sum_q,   sum_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               acc_sat_q, acc_sat_d;

  logic [SUM_W-1:0]   w_sum_add;
  logic [ACC_W-1:0]   w_clamp;
  logic               w_clamp_sat;

  assign w_sum_add = sum_q + {{GUARD{prod[63]}}, prod};

  // Clamp the post-add sum so the result is ready the cycle DONE is entered.
  sat_clamp #(
    .GUARD (GUARD)
  ) u_sat_clamp (
    .i_sum (w_sum_add),
    .o_acc (w_clamp),
    .o_sat (w_clamp_sat)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sum_d     = sum_q;
    acc_d     = acc_q;
    acc_sat_d = acc_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d = '0;
          if (len == '0) begin
            state_d   = ST_DONE;
            acc_d     = '0;
            acc_sat_d = 1'b0;
          end else begin
            count_d = len;
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (prod_valid) begin
          sum_d   = w_sum_add;
          count_d = count_q - LEN_W'(1);
          if (count_q == LEN_W'(1)) begin
            state_d   = ST_DONE;
            acc_d     = w_clamp;
            acc_sat_d = w_clamp_sat;
          end
        end
      end
      ST_DONE: begin
        if (acc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      sum_q     <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
    end
  end

  assign prod_ready = (state_q == ST_ACCUM);
  assign acc_valid  = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign acc        = acc_q;
  assign acc_sat    = acc_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_accumulator.sv
// ============================================================================
// tb_mul_accumulator : directed self-checking bench for mul_accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mul_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        prod_valid;
  logic [63:0] prod;
  logic        prod_ready;
  logic        acc_valid;
  logic [63:0] acc;
  logic        acc_sat;
  logic        acc_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int n_rdy   = 0;
  int snap;

  mul_accumulator #(
    .LEN_W (8),
    .GUARD (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .prod_valid (prod_valid),
    .prod       (prod),
    .prod_ready (prod_ready),
    .acc_valid  (acc_valid),
    .acc        (acc),
    .acc_sat    (acc_sat),
    .acc_ready  (acc_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Handshake observers: what the DUT saw at each rising edge.
  always @(posedge clk) begin
    if (reset && prod_valid && prod_ready) n_acc++;
    if (prod_ready) n_rdy++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic start_blk(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic feed(input logic [63:0] p, input int gap);
    for (int i = 0; i < gap; i++) begin
      prod_valid = 1'b0;
      @(negedge clk);
    end
    check_eq("ready_before_accept", {63'd0, prod_ready}, 64'd1);
    check_eq("no_valid_in_accum", {63'd0, acc_valid}, 64'd0);
    prod_valid = 1'b1;
    prod       = p;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic finish_blk(input string tag, input logic [63:0] exp_acc, input logic exp_sat);
    check_eq({tag, "_valid"}, {63'd0, acc_valid}, 64'd1);
    check_eq({tag, "_acc"}, acc, exp_acc);
    check_eq({tag, "_sat"}, {63'd0, acc_sat}, {63'd0, exp_sat});
    acc_ready = 1'b1;
    @(negedge clk);
    acc_ready = 1'b0;
    check_eq({tag, "_idle_valid"}, {63'd0, acc_valid}, 64'd0);
    check_eq({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check_eq({tag, "_idle_acc"}, acc, exp_acc);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_acc"}, acc, 64'd0);
    check_eq({tag, "_sat"}, {63'd0, acc_sat}, 64'd0);
    check_eq({tag, "_valid"}, {63'd0, acc_valid}, 64'd0);
    check_eq({tag, "_ready"}, {63'd0, prod_ready}, 64'd0);
    check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    len        = 8'd0;
    prod_valid = 1'b0;
    prod       = 64'd0;
    acc_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // -35 + 6 + 48 = 19
    start_blk(8'd3);
    check_eq("busy_accum", {63'd0, busy}, 64'd1);
    feed(-64'sd35, 0);
    feed(64'sd6, 0);
    feed(64'sd48, 0);
    finish_blk("sum3", 64'd19, 1'b0);

    // Empty block: result next cycle, never ready for products
    snap = n_rdy;
    start_blk(8'd0);
    finish_blk("len0", 64'd0, 1'b0);
    check_eq("len0_no_ready", 64'(n_rdy - snap), 64'd0);

    // 2^62 + 2^62 = 2^63 overflows positive
    start_blk(8'd2);
    feed(64'h4000_0000_0000_0000, 0);
    feed(64'h4000_0000_0000_0000, 0);
    finish_blk("sat_pos", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

    // 3 * -2^62 < -2^63 overflows negative
    start_blk(8'd3);
    feed(64'hC000_0000_0000_0000, 0);
    feed(64'hC000_0000_0000_0000, 0);
    feed(64'hC000_0000_0000_0000, 0);
    finish_blk("sat_neg", 64'h8000_0000_0000_0000, 1'b1);

    // Gapped prod_valid: 10 - 9 + 7 + 0 = 8 with exactly 4 accepts
    snap = n_acc;
    start_blk(8'd4);
    feed(64'sd10, 1);
    feed(-64'sd9, 1);
    feed(64'sd7, 1);
    feed(64'sd0, 1);
    finish_blk("gaps", 64'd8, 1'b0);
    check_eq("gaps_accepts", 64'(n_acc - snap), 64'd4);

    // Back-pressure: result held, start and products ignored in DONE
    start_blk(8'd1);
    feed(-64'sd5, 0);
    snap = n_acc;
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_valid", {63'd0, acc_valid}, 64'd1);
      check_eq("hold_acc", acc, -64'sd5);
      check_eq("hold_sat", {63'd0, acc_sat}, 64'd0);
      start      = (i == 2);
      len        = 8'd3;
      prod_valid = 1'b1;
      prod       = 64'd100;
      @(negedge clk);
    end
    start      = 1'b0;
    len        = 8'd0;
    prod_valid = 1'b0;
    check_eq("hold_no_accept", 64'(n_acc - snap), 64'd0);
    finish_blk("hold", -64'sd5, 1'b0);
    @(negedge clk);
    check_eq("hold_stays_idle", {63'd0, busy}, 64'd0);

    // Reset mid-block abandons the partial sum
    start_blk(8'd3);
    feed(64'sd77, 0);
    reset      = 1'b0;
    start      = 1'b1;
    len        = 8'd5;
    prod_valid = 1'b1;
    prod       = 64'd999;
    @(negedge clk);
    check_all_zero("midrst1");
    @(negedge clk);
    check_all_zero("midrst2");
    reset      = 1'b1;
    start      = 1'b0;
    len        = 8'd0;
    prod_valid = 1'b0;
    @(negedge clk);
    start_blk(8'd1);
    feed(64'sd10, 0);
    finish_blk("after_rst", 64'd10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
